// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit framer: frame states,
// line-select encoding for the serial output stage and a frame-length helper.
package uart_pkg;

    // Frame state machine states.
    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line-select code that picks the value driven onto the serial pin.
    typedef logic [1:0] line_sel_t;

    localparam line_sel_t SEL_START  = 2'b00;
    localparam line_sel_t SEL_DATA   = 2'b01;
    localparam line_sel_t SEL_PARITY = 2'b10;
    localparam line_sel_t SEL_IDLE   = 2'b11;   // also used for the stop bits

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_ticks(input int data_bits, input int parity_en,
                                       input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer. Takes one word per valid/ready handshake and sends it
// as start bit, data bits LSB-first, optional parity bit and 1 or 2 stop bits,
// advancing one bit per external baud_tick strobe. The serial line is driven
// from a registered line-select output stage so tx_out never glitches.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             ODD_BIT   = 1'(PARITY_ODD);

    // Reject unsupported frame formats at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be 5..9");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_parity_en
        $error("uart_tx_framer: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    state_t               state_q,    state_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic                 parity_q,   parity_d;
    logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 ready_q,    ready_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 tx_out_q;
    line_sel_t            sel_d;

    // Next-state logic for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (tx_valid && ready_q) begin
                    // A tick in the accept cycle is ignored: ARMED waits for
                    // the next one so the start bit lasts a full interval.
                    shreg_d    = tx_data;
                    parity_d   = (^tx_data) ^ ODD_BIT;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (baud_tick) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line select follows the state being entered, so the pin changes on the
    // same edge as the state transition.
    always_comb begin
        unique case (state_d)
            START:   sel_d = SEL_START;
            DATA:    sel_d = SEL_DATA;
            PARITY:  sel_d = SEL_PARITY;
            default: sel_d = SEL_IDLE;
        endcase
    end

    // Frame sequencer state, datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is cleared so a mid-frame reset discards the frame completely.
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together on the edge.
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Registered line-select mux driving the serial pin; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_out_q <= 1'b1;
        end else begin
            unique case (sel_d)
                SEL_START:  tx_out_q <= 1'b0;
                SEL_DATA:   tx_out_q <= shreg_d[0];
                SEL_PARITY: tx_out_q <= parity_d;
                default:    tx_out_q <= 1'b1;
            endcase
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign tx_out   = tx_out_q;

endmodule
